// File: rtl/dmem_responder.sv
// Block data-memory responder: serves one DATA_W block per request after a fixed
// LATENCY, stalling the cache initiator with WAIT while the access is in flight.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 98
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              WAIT,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    // Request cycle in IDLE plus BUSY cycles counting down to zero totals LATENCY.
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              illegal;
    logic              acc_en;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    assign req       = read ^ write;
    assign illegal   = read & write;
    assign read_data = read_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        acc_en     = 1'b0;
        acc_write  = op_write_q;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        WAIT       = 1'b0;
        err        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    WAIT       = 1'b1;
                    op_write_d = write;
                    addr_d     = address;
                    wdata_d    = write_data;
                    if (LATENCY > 1) begin
                        cnt_d   = CNT_INIT;
                        state_d = StBusy;
                    end else begin
                        // Single-cycle latency: access straight from the live inputs.
                        acc_en    = 1'b1;
                        acc_write = write;
                        acc_addr  = address;
                        acc_wdata = write_data;
                        state_d   = StDone;
                    end
                end else if (illegal) begin
                    err = 1'b1;
                end
            end
            StBusy: begin
                WAIT = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    acc_en  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (reset) begin
            WAIT = 1'b0;
            err  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if (acc_en) begin
                if (acc_write) begin
                    mem[acc_addr] <= acc_wdata;
                end else begin
                    read_data_q <= mem[acc_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=98 instance and a LATENCY=1 instance
// share stimulus, steered by sel1; expected values are hand-computed.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [6:0]  address;
    logic [15:0] write_data;
    logic        sel1;

    logic [15:0] read_data0, read_data1;
    logic        wait0, wait1, err0, err1;
    logic        wait_sel, err_sel;
    logic [15:0] rdata_sel;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int nwait;

    dmem_responder #(
        .ADDR_W (7),
        .DATA_W (16),
        .DEPTH  (128),
        .LATENCY(98)
    ) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .read      (read & ~sel1),
        .write     (write & ~sel1),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data0),
        .WAIT      (wait0),
        .err       (err0)
    );

    dmem_responder #(
        .ADDR_W (7),
        .DATA_W (16),
        .DEPTH  (128),
        .LATENCY(1)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .read      (read & sel1),
        .write     (write & sel1),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data1),
        .WAIT      (wait1),
        .err       (err1)
    );

    assign wait_sel  = sel1 ? wait1 : wait0;
    assign err_sel   = sel1 ? err1 : err0;
    assign rdata_sel = sel1 ? read_data1 : read_data0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_sel) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts a request one cycle on, counts WAIT-high cycles, returns in the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [6:0] a,
                          input logic [15:0] d, input bit hold, input int chg,
                          input logic [6:0] a2, input logic [15:0] d2, output int n);
        @(posedge clk);
        #1;
        read = rd;
        write = wr;
        address = a;
        write_data = d;
        n = 0;
        #2;
        while (wait_sel && n < 500) begin
            n++;
            if (n == chg) begin
                address = a2;
                write_data = d2;
            end
            @(posedge clk);
            #3;
        end
        if (!hold) begin
            read = 1'b0;
            write = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        read = 1'b1;
        write = 1'b0;
        address = 7'h00;
        write_data = 16'h0000;
        sel1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("wait_in_reset", {31'b0, wait0}, 32'h0);
        read = 1'b0;
        reset = 1'b0;
        #2;
        check_eq("rst_wait", {31'b0, wait0}, 32'h0);
        check_eq("rst_rdata", {16'b0, read_data0}, 32'h0);
        check_eq("rst_err", {31'b0, err0}, 32'h0);

        // Read of untouched address
        access(1'b1, 1'b0, 7'h23, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("rd23_wait", nwait, 98);
        check_eq("rd23_data", {16'b0, rdata_sel}, 32'h0000);

        // Write then read back
        access(1'b0, 1'b1, 7'h11, 16'h0731, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("wr11_wait", nwait, 98);
        check_eq("wr11_rdata_kept", {16'b0, rdata_sel}, 32'h0000);
        access(1'b1, 1'b0, 7'h11, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("rd11_wait", nwait, 98);
        check_eq("rd11_data", {16'b0, rdata_sel}, 32'h0731);
        check_eq("no_err_yet", err_cnt, 0);

        // LATENCY=1 instance
        @(posedge clk);
        sel1 = 1'b1;
        access(1'b0, 1'b1, 7'h05, 16'hBEEF, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("l1_wr_wait", nwait, 1);
        check_eq("l1_wr_rdata", {16'b0, rdata_sel}, 32'h0000);
        access(1'b1, 1'b0, 7'h05, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("l1_rd_wait", nwait, 1);
        check_eq("l1_rd_data", {16'b0, rdata_sel}, 32'hBEEF);
        @(posedge clk);
        sel1 = 1'b0;

        // Inputs changed mid-BUSY must be ignored
        access(1'b0, 1'b1, 7'h22, 16'h0106, 1'b0, 10, 7'h33, 16'hFFFF, nwait);
        check_eq("midbusy_wait", nwait, 98);
        access(1'b1, 1'b0, 7'h22, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("midbusy_rd22", {16'b0, rdata_sel}, 32'h0106);
        access(1'b1, 1'b0, 7'h33, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("midbusy_rd33", {16'b0, rdata_sel}, 32'h0000);

        // Illegal request for three IDLE cycles
        @(posedge clk);
        #1;
        read = 1'b1;
        write = 1'b1;
        address = 7'h11;
        write_data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_eq($sformatf("ill_err%0d", i), {31'b0, err0}, 32'h1);
            check_eq($sformatf("ill_wait%0d", i), {31'b0, wait0}, 32'h0);
            @(posedge clk);
            #1;
        end
        read = 1'b0;
        write = 1'b0;
        #2;
        check_eq("ill_err_cnt", err_cnt, 3);
        access(1'b1, 1'b0, 7'h11, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("ill_mem_kept", {16'b0, rdata_sel}, 32'h0731);

        // Reset in the middle of a write
        @(posedge clk);
        #1;
        write = 1'b1;
        address = 7'h10;
        write_data = 16'h00AA;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_eq("rst_mid_wait", {31'b0, wait0}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        write = 1'b0;
        access(1'b1, 1'b0, 7'h10, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("rst_rd10_wait", nwait, 98);
        check_eq("rst_rd10_data", {16'b0, rdata_sel}, 32'h0000);
        access(1'b1, 1'b0, 7'h11, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("rst_cleared11", {16'b0, rdata_sel}, 32'h0000);

        // Request held through DONE re-executes
        access(1'b1, 1'b0, 7'h22, 16'h0, 1'b1, 0, 7'h0, 16'h0, nwait);
        check_eq("hold_burst1", nwait, 98);
        check_eq("hold_done_wait", {31'b0, wait0}, 32'h0);
        access(1'b1, 1'b0, 7'h22, 16'h0, 1'b0, 0, 7'h0, 16'h0, nwait);
        check_eq("hold_burst2", nwait, 98);
        check_eq("final_err_cnt", err_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
